// File: rtl/retro_memory_bram_target.sv
// Retro-1 memory-port target on inferred synchronous block RAM with fixed-latency reads and RMW partial writes.
// Optional power-up zero sweep of the whole RAM: define RETRO_MEMORY_BRAM_CLEAR_EN.
module retro_memory_bram_target #(
  parameter int AddressBusWidth = 16,
  parameter int DataBusWidth    = 1,
  parameter int DepthLog2       = 12,
  parameter int ReadLatency     = 2
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic [AddressBusWidth-1:0]   Address,
  input  logic [8*DataBusWidth-1:0]    Din,
  input  logic [8*DataBusWidth-1:0]    Access,
  input  logic                         Write,
  output logic [8*DataBusWidth-1:0]    Dout,
  output logic                         Ready,
  output logic                         DataReady
);

  localparam int DW    = 8 * DataBusWidth;
  localparam int Depth = 2 ** DepthLog2;

  typedef logic [DW-1:0]        word_t;
  typedef logic [DepthLog2-1:0] idx_t;

`ifdef RETRO_MEMORY_BRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RMW = 2'd1, CLEAR = 2'd2} state_t;
  localparam state_t ResetState = CLEAR;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RMW = 2'd1} state_t;
  localparam state_t ResetState = IDLE;
`endif

  word_t  mem_q [Depth];
  word_t  rd_q;
  state_t state_q, state_d;
  logic   ready_q, ready_d;
  idx_t   rmw_addr_q, rmw_addr_d;
  word_t  rmw_din_q, rmw_din_d;
  word_t  rmw_mask_q, rmw_mask_d;
`ifdef RETRO_MEMORY_BRAM_CLEAR_EN
  idx_t   clr_addr_q, clr_addr_d;
`endif
  logic [ReadLatency:0] vld_q, vld_d;
  word_t  data_q [ReadLatency];
  word_t  data_d [ReadLatency];

  logic   accept_s, rd_acc_s, mem_we_s;
  idx_t   addr_s, mem_waddr_s;
  word_t  mem_wdata_s;

  // Upper address bits are ignored so the RAM aliases.
  assign addr_s   = Address[DepthLog2-1:0];
  assign accept_s = ready_q && (Access != {DW{1'b0}});

  generate
    if (DepthLog2 < AddressBusWidth) begin : g_alias
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^Address[AddressBusWidth-1:DepthLog2];
    end
  endgenerate

  // Command decode, RMW merge and the single RAM write port.
  always_comb begin
    state_d     = state_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_din_d   = rmw_din_q;
    rmw_mask_d  = rmw_mask_q;
`ifdef RETRO_MEMORY_BRAM_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif
    rd_acc_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_s;
    mem_wdata_s = Din;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (!Write) begin
            rd_acc_s = 1'b1;
          end else if (Access == {DW{1'b1}}) begin
            mem_we_s = 1'b1;
          end else begin
            state_d    = RMW;
            rmw_addr_d = addr_s;
            rmw_din_d  = Din;
            rmw_mask_d = Access;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RMW: begin
        // rd_q holds the old word, read at the accept edge.
        mem_we_s    = 1'b1;
        mem_waddr_s = rmw_addr_q;
        mem_wdata_s = (rd_q & ~rmw_mask_q) | (rmw_din_q & rmw_mask_q);
        state_d     = IDLE;
      end
`ifdef RETRO_MEMORY_BRAM_CLEAR_EN
      CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_addr_q;
        mem_wdata_s = {DW{1'b0}};
        clr_addr_d  = clr_addr_q + idx_t'(1'b1);
        if (clr_addr_q == {DepthLog2{1'b1}}) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // Read pipeline: the BRAM output register feeds ReadLatency data stages.
  always_comb begin
    vld_d     = {vld_q[ReadLatency-1:0], rd_acc_s};
    data_d[0] = rd_q;
    for (int i = 1; i < ReadLatency; i++) begin
      data_d[i] = data_q[i-1];
    end
  end

  // RAM array with synchronous read, kept free of reset so it maps to block RAM.
  always_ff @(posedge Clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
    rd_q <= mem_q[addr_s];
  end

  // Control state and read pipeline registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ResetState;
      ready_q    <= 1'b0;
      rmw_addr_q <= {DepthLog2{1'b0}};
      rmw_din_q  <= {DW{1'b0}};
      rmw_mask_q <= {DW{1'b0}};
`ifdef RETRO_MEMORY_BRAM_CLEAR_EN
      clr_addr_q <= {DepthLog2{1'b0}};
`endif
      vld_q      <= {(ReadLatency+1){1'b0}};
      for (int i = 0; i < ReadLatency; i++) begin
        data_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_din_q  <= rmw_din_d;
      rmw_mask_q <= rmw_mask_d;
`ifdef RETRO_MEMORY_BRAM_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
      vld_q      <= vld_d;
      for (int i = 0; i < ReadLatency; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign Ready     = ready_q;
  assign DataReady = vld_q[ReadLatency];
  assign Dout      = data_q[ReadLatency-1];

endmodule
